// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
// Contents: FSM state encoding, default operand width, counter width helper.
package seq_divider_pkg;

   localparam int unsigned DIV_WIDTH_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   // Step counter width; at least one bit so degenerate widths still elaborate
   function automatic int unsigned cnt_width(input int unsigned w);
      return (w <= 1) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Start/done handshake bundle between the datapath controller and the divider.
// master: controller side (drives start and operands, reads status/results)
// slave : divider side (reads start and operands, drives status/results)
interface seq_divider_if
   import seq_divider_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) ();

   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );

endinterface

// File: rtl/seq_divider_sub_ripple.sv
// Combinational W-bit ripple-borrow subtractor (i_a - i_b) from full-subtractor cells.
// Ports: i_a, i_b  operands
//        o_d_c     difference, modulo 2^W
//        o_bo_c    borrow out (1 when i_a < i_b)
module sub_ripple #(
   parameter int unsigned W = 5
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   output logic [W-1:0] o_d_c,
   output logic         o_bo_c
);

   logic [W:0] w_borrow;

   assign w_borrow[0] = 1'b0;

   // One full-subtractor cell per bit
   for (genvar g = 0; g < W; g++) begin : g_fs
      assign o_d_c[g]      = i_a[g] ^ i_b[g] ^ w_borrow[g];
      assign w_borrow[g+1] = (~i_a[g] & i_b[g]) | (~(i_a[g] ^ i_b[g]) & w_borrow[g]);
   end

   assign o_bo_c = w_borrow[W];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Ports: clk    system clock
//        rst_n  asynchronous active-low reset
//        bus    slave side of seq_divider_if (start/operands in, busy/done/results out)
// Status and results are registered from the FSM state, so they trail the
// state by one edge: done rises WIDTH+1 edges after the accepted start
// (1 edge for divide-by-zero) and results are valid with done and held after.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic            clk,
   input  logic            rst_n,
   seq_divider_if.slave    bus
);

   localparam int unsigned CW = cnt_width(WIDTH);
   localparam int unsigned RW = WIDTH + 1;

   state_e           r_state;
   state_e           w_next_state;
   logic             w_accept;
   logic             w_last;

   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_d;
   logic [RW-1:0]    r_r;
   logic [CW-1:0]    r_cnt;
   logic             r_dbz_pend;

   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_quot;
   logic [WIDTH-1:0] r_rem;
   logic             r_dbz;

   logic [RW-1:0]    w_rs;
   logic [RW-1:0]    w_diff;
   logic             w_bo;
   logic             w_unused;

   // Shifted partial remainder and trial subtraction of the divisor
   assign w_rs = {r_r[WIDTH-1:0], r_q[WIDTH-1]};

   sub_ripple #(.W(RW)) u_sub (
      .i_a    (w_rs),
      .i_b    ({1'b0, r_d}),
      .o_d_c  (w_diff),
      .o_bo_c (w_bo)
   );

   // After every restoring step R < D, so the top remainder bit never feeds back
   assign w_unused = r_r[WIDTH];

   assign w_last = (r_cnt == CW'(WIDTH - 1));

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   // Next-state logic; DONE accepts a new start just like IDLE
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            w_next_state = IDLE;
            if (bus.start) begin
               w_accept     = 1'b1;
               w_next_state = (bus.divisor == '0) ? DONE : CALC;
            end
         end
         CALC: begin
            if (w_last) w_next_state = DONE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Working registers: operand capture and one shift/subtract step per cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q        <= '0;
         r_d        <= '0;
         r_r        <= '0;
         r_cnt      <= '0;
         r_dbz_pend <= 1'b0;
      end else if (w_accept) begin
         r_d   <= bus.divisor;
         r_cnt <= '0;
         if (bus.divisor == '0) begin
            // Divide-by-zero result is preloaded so DONE can publish it unchanged
            r_q        <= '1;
            r_r        <= RW'(bus.dividend);
            r_dbz_pend <= 1'b1;
         end else begin
            r_q        <= bus.dividend;
            r_r        <= '0;
            r_dbz_pend <= 1'b0;
         end
      end else if (r_state == CALC) begin
         r_r   <= w_bo ? w_rs : w_diff;
         r_q   <= {r_q[WIDTH-2:0], ~w_bo};
         r_cnt <= r_cnt + CW'(1);
      end
   end

   // Registered status and held results
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_quot <= '0;
         r_rem  <= '0;
         r_dbz  <= 1'b0;
      end else begin
         r_busy <= (r_state == CALC);
         r_done <= (r_state == DONE);
         if (r_state == DONE) begin
            r_quot <= r_q;
            r_rem  <= r_r[WIDTH-1:0];
            r_dbz  <= r_dbz_pend;
         end
      end
   end

   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.quotient    = r_quot;
   assign bus.remainder   = r_rem;
   assign bus.div_by_zero = r_dbz;

endmodule
